// File: rtl/approx_err_pkg.sv
// Shared state encoding, width defaults and saturation constant for the
// approximate-multiplier error accumulator.
package approx_err_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int W_DEF     = 16;
   localparam int CNT_W_DEF = 33;
   localparam int ACC_W_DEF = 64;

   localparam logic [ACC_W_DEF-1:0] ACC_MAX = {ACC_W_DEF{1'b1}};

endpackage

// File: rtl/approx_err_stage.sv
// Two-stage error datapath: S1 forms the exact product, S2 the absolute
// error distance and its nonzero flag.
module approx_err_stage
   import approx_err_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_fire,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [2*W-1:0] y_approx,
   output logic           s1_valid,
   output logic           s2_valid,
   output logic [2*W-1:0] ed,
   output logic           ne
);

   localparam logic [2*W-1:0] P_ZERO = {(2*W){1'b0}};

   logic           s1_valid_r;
   logic [2*W-1:0] exact_r;
   logic [2*W-1:0] y_r;
   logic           s2_valid_r;
   logic [2*W-1:0] ed_r;
   logic           ne_r;
   logic [2*W-1:0] ed_s;

   // Larger-minus-smaller keeps the distance unsigned without a wider subtract.
   always_comb begin
      ed_s = P_ZERO;
      if (exact_r >= y_r) begin
         ed_s = exact_r - y_r;
      end else begin
         ed_s = y_r - exact_r;
      end
   end

   // S1/S2 pipeline registers with their valid bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         exact_r    <= P_ZERO;
         y_r        <= P_ZERO;
         s2_valid_r <= 1'b0;
         ed_r       <= P_ZERO;
         ne_r       <= 1'b0;
      end else begin
         s1_valid_r <= in_fire;
         if (in_fire) begin
            exact_r <= (2*W)'(a) * (2*W)'(b);
            y_r     <= y_approx;
         end
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            ed_r <= ed_s;
            ne_r <= (ed_s != P_ZERO);
         end
      end
   end

   assign s1_valid = s1_valid_r;
   assign s2_valid = s2_valid_r;
   assign ed       = ed_r;
   assign ne       = ne_r;

endmodule

// File: rtl/approx_mult_err_accum.sv
// Windowed error-metric accumulator for an approximate multiplier: counts
// errors, sums and tracks the maximum error distance over n_samples inputs.
module approx_mult_err_accum
   import approx_err_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] n_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [2*W-1:0]   y_approx,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [ACC_W-1:0] sum_ed,
   output logic [2*W-1:0]   max_ed,
   output logic [CNT_W-1:0] sample_count
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ACC_W-1:0] SUM_ZERO = {ACC_W{1'b0}};
   localparam logic [ACC_W-1:0] SUM_MAX  = {ACC_W{1'b1}};
   localparam logic [2*W-1:0]   P_ZERO   = {(2*W){1'b0}};

   state_e           state_r;
   logic [CNT_W-1:0] n_lat_r;
   logic [CNT_W-1:0] accepted_r;
   logic             in_ready_r;
   logic             busy_r;
   logic             done_r;
   logic [CNT_W-1:0] err_count_r;
   logic [ACC_W-1:0] sum_ed_r;
   logic [2*W-1:0]   max_ed_r;
   logic [CNT_W-1:0] sample_count_r;

   logic             fire_s;
   logic [CNT_W-1:0] accepted_inc_s;
   logic             s1_valid_s;
   logic             s2_valid_s;
   logic [2*W-1:0]   ed_s;
   logic             ne_s;
   logic [ACC_W:0]   sum_wide_s;
   logic [ACC_W-1:0] sum_nxt_s;

   assign fire_s         = in_valid & in_ready_r;
   assign accepted_inc_s = accepted_r + CNT_ONE;

   approx_err_stage #(.W(W)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_fire  (fire_s),
      .a        (a),
      .b        (b),
      .y_approx (y_approx),
      .s1_valid (s1_valid_s),
      .s2_valid (s2_valid_s),
      .ed       (ed_s),
      .ne       (ne_s)
   );

   // Saturating add: the carry out of the widened sum pins the total at all-ones.
   always_comb begin
      sum_wide_s = {1'b0, sum_ed_r} + {{(ACC_W+1-2*W){1'b0}}, ed_s};
      if (sum_wide_s[ACC_W]) begin
         sum_nxt_s = SUM_MAX;
      end else begin
         sum_nxt_s = sum_wide_s[ACC_W-1:0];
      end
   end

   // Window FSM, handshake accounting and result accumulators.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         n_lat_r        <= CNT_ZERO;
         accepted_r     <= CNT_ZERO;
         in_ready_r     <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         err_count_r    <= CNT_ZERO;
         sum_ed_r       <= SUM_ZERO;
         max_ed_r       <= P_ZERO;
         sample_count_r <= CNT_ZERO;
      end else begin
         if (s2_valid_s) begin
            err_count_r    <= err_count_r + {{(CNT_W-1){1'b0}}, ne_s};
            sample_count_r <= sample_count_r + CNT_ONE;
            sum_ed_r       <= sum_nxt_s;
            if (ed_s > max_ed_r) begin
               max_ed_r <= ed_s;
            end
         end
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  n_lat_r        <= n_samples;
                  accepted_r     <= CNT_ZERO;
                  err_count_r    <= CNT_ZERO;
                  sum_ed_r       <= SUM_ZERO;
                  max_ed_r       <= P_ZERO;
                  sample_count_r <= CNT_ZERO;
                  busy_r         <= 1'b1;
                  done_r         <= 1'b0;
                  if (n_samples == CNT_ZERO) begin
                     state_r    <= DRAIN;
                     in_ready_r <= 1'b0;
                  end else begin
                     state_r    <= RUN;
                     in_ready_r <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (fire_s) begin
                  accepted_r <= accepted_inc_s;
                  // Last handshake closes the window on the same edge.
                  if (accepted_inc_s == n_lat_r) begin
                     in_ready_r <= 1'b0;
                     state_r    <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!s1_valid_s && !s2_valid_s && (sample_count_r == n_lat_r)) begin
                  state_r <= DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               state_r    <= IDLE;
               in_ready_r <= 1'b0;
               busy_r     <= 1'b0;
               done_r     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = in_ready_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign err_count    = err_count_r;
   assign sum_ed       = sum_ed_r;
   assign max_ed       = max_ed_r;
   assign sample_count = sample_count_r;

endmodule

// File: tb/tb_approx_mult_err_accum.sv
// Scoreboard bench: each window pushes its expected results; a monitor pops and
// compares them when done rises.
module tb_approx_mult_err_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [32:0] n_samples;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [31:0] y_approx;
   logic        busy;
   logic        done;
   logic [32:0] err_count;
   logic [63:0] sum_ed;
   logic [31:0] max_ed;
   logic [32:0] sample_count;

   typedef struct {
      logic [32:0] err;
      logic [63:0] sum;
      logic [31:0] mx;
      logic [32:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic done_q = 1'b0;

   approx_mult_err_accum dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .n_samples    (n_samples),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .a            (a),
      .b            (b),
      .y_approx     (y_approx),
      .busy         (busy),
      .done         (done),
      .err_count    (err_count),
      .sum_ed       (sum_ed),
      .max_ed       (max_ed),
      .sample_count (sample_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Monitor: compare results against the scoreboard on each rising done.
   always @(negedge clk) begin
      if (done && !done_q) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("err_count", 64'(err_count), 64'(e.err));
            chk("sum_ed", sum_ed, e.sum);
            chk("max_ed", 64'(max_ed), 64'(e.mx));
            chk("sample_count", 64'(sample_count), 64'(e.cnt));
         end
      end
      done_q <= done;
   end

   task automatic push_exp(input logic [32:0] e_err, input logic [63:0] e_sum,
                           input logic [31:0] e_mx, input logic [32:0] e_cnt);
      exp_t e;
      e.err = e_err; e.sum = e_sum; e.mx = e_mx; e.cnt = e_cnt;
      exp_q.push_back(e);
   endtask

   task automatic do_start(input logic [32:0] n);
      @(negedge clk);
      start = 1'b1;
      n_samples = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a negedge; in_ready is registered so it predicts the handshake.
   task automatic send(input logic [15:0] av, input logic [15:0] bv,
                       input logic [31:0] yv, output logic acc);
      in_valid = 1'b1; a = av; b = bv; y_approx = yv;
      acc = in_ready;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cycles);
      cycles = 0;
      while (!done && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      if (!done) chk("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      logic        acc;
      int          cyc;
      int          nacc;
      logic [15:0] ra, rb;
      logic [31:0] gap_pat;

      rst_n = 1'b0; start = 1'b0; n_samples = 33'd0; in_valid = 1'b0;
      a = 16'd0; b = 16'd0; y_approx = 32'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_sample_count", 64'(sample_count), 64'd0);

      // Exact multiplier, 1000 random samples back to back.
      push_exp(33'd0, 64'd0, 32'd0, 33'd1000);
      do_start(33'd1000);
      nacc = 0;
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         send(ra, rb, 32'(ra) * 32'(rb), acc);
         if (acc) nacc++;
      end
      chk("exact_accepted", 64'(nacc), 64'd1000);
      chk("exact_ready_low", 64'(in_ready), 64'd0);
      wait_done(20, cyc);
      chk("exact_drain_latency", 64'(cyc), 64'd3);

      // Directed errors, including the full-scale product.
      push_exp(33'd2, 64'd4294836226, 32'd4294836225, 33'd3);
      do_start(33'd3);
      send(16'd3, 16'd5, 32'd14, acc);
      send(16'd65535, 16'd65535, 32'd0, acc);
      send(16'd2, 16'd2, 32'd4, acc);
      wait_done(20, cyc);
      chk("directed_latency", 64'(cyc), 64'd3);

      // Empty window.
      push_exp(33'd0, 64'd0, 32'd0, 33'd0);
      do_start(33'd0);
      chk("n0_ready", 64'(in_ready), 64'd0);
      wait_done(20, cyc);
      chk("n0_fast", 64'(cyc <= 2), 64'd1);
      chk("n0_ready_done", 64'(in_ready), 64'd0);

      // Gapped valid, y = a*b+1, then extra samples after the window.
      push_exp(33'd16, 64'd16, 32'd1, 33'd16);
      do_start(33'd16);
      gap_pat = 32'hA5C3_96E1;
      nacc = 0;
      for (int k = 0; k < 200 && nacc < 16; k++) begin
         if (gap_pat[k % 32]) begin
            @(negedge clk);
         end else begin
            ra = 16'(k + 1);
            send(ra, 16'd7, 32'(ra) * 32'd7 + 32'd1, acc);
            if (acc) nacc++;
         end
      end
      chk("gap_accepted", 64'(nacc), 64'd16);
      chk("gap_ready_low", 64'(in_ready), 64'd0);
      for (int k = 0; k < 3; k++) begin
         send(16'd100, 16'd100, 32'd0, acc);
         chk("gap_extra_ignored", 64'(acc), 64'd0);
      end
      wait_done(20, cyc);

      // Asynchronous reset mid-window discards everything.
      do_start(33'd8);
      for (int i = 1; i <= 5; i++) begin
         send(16'(i), 16'(i), 32'(i * i + 1), acc);
      end
      chk("pre_reset_count", 64'(sample_count), 64'd3);
      chk("pre_reset_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_ready", 64'(in_ready), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_err", 64'(err_count), 64'd0);
      chk("arst_sum", sum_ed, 64'd0);
      chk("arst_max", 64'(max_ed), 64'd0);
      chk("arst_count", 64'(sample_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      push_exp(33'd4, 64'd8, 32'd2, 33'd4);
      do_start(33'd4);
      for (int i = 1; i <= 4; i++) begin
         send(16'(i), 16'd9, 32'(i * 9 + 2), acc);
      end
      wait_done(20, cyc);
      chk("post_reset_latency", 64'(cyc), 64'd3);

      // A start during RUN must not shorten the window.
      push_exp(33'd10, 64'd55, 32'd10, 33'd10);
      do_start(33'd10);
      nacc = 0;
      for (int i = 1; i <= 10; i++) begin
         if (i == 4) begin
            start = 1'b1;
            n_samples = 33'd2;
         end
         send(16'(i), 16'd3, 32'(i * 3 + i), acc);
         start = 1'b0;
         if (acc) nacc++;
      end
      chk("restart_accepted", 64'(nacc), 64'd10);
      chk("restart_ready_low", 64'(in_ready), 64'd0);
      wait_done(20, cyc);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/approx_mult_err_accum.md
Name: approx_mult_err_accum

Overview:
- Hardware error-metric accumulator placed directly downstream of the 16x16 approximate multiplier (n16_5 family).
- Consumes operand pairs with their approximate products, computes the exact product internally, and accumulates error count, sum of error distance and maximum error distance over a programmed sample window.
- Replaces simulator-side exhaustive checking, so sweeps can run on FPGA at one sample per clock.

Parameters:
- W, 16, operand width; the product is 2*W bits.
- CNT_W, 33, width of the sample counter and error counter. 33 bits holds 2^32 samples.
- ACC_W, 64, width of the sum-of-error-distance accumulator.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; arms a new measurement window. Ignored unless the state is IDLE or DONE.
- n_samples  input  CNT_W  window length; sampled when start is accepted.
- in_valid  input  1  an operand/product sample is present.
- in_ready  output  1  the block accepts a sample this cycle.
- a  input  W  multiplicand applied to the approximate multiplier.
- b  input  W  multiplier applied to the approximate multiplier.
- y_approx  input  2W  approximate product Y from the multiplier.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE; results are stable.
- err_count  output  CNT_W  number of samples where y_approx != a*b.
- sum_ed  output  ACC_W  sum of |a*b - y_approx|, saturating.
- max_ed  output  2W  largest |a*b - y_approx| seen in the window.
- sample_count  output  CNT_W  samples retired into the accumulators.

Behaviour:
- Reset (asynchronous, rst_n=0): state goes to IDLE. in_ready, busy, done = 0. err_count, sum_ed, max_ed, sample_count = 0. Pipeline valid bits are cleared.
- Reset asserted mid-window aborts the window and discards all partial results.
- A handshake occurs when in_valid && in_ready. in_ready = 1 only in RUN while accepted < n_samples_latched.
- State machine:
  - IDLE: on start, latch n_samples and clear all accumulators and counters. Go to RUN, or to DRAIN if n_samples == 0.
  - RUN: accept samples. When the accepted count reaches n_samples_latched, drop in_ready in that same cycle and go to DRAIN.
  - DRAIN: wait until both pipeline stages are empty, then go to DONE.
  - DONE: done = 1 and outputs hold. start re-enters the IDLE start action: clear, then RUN.
- Pipeline: 2 stages, no backpressure inside.
  - S1 registers a, b, y_approx and the exact product a*b (2W bits, unsigned).
  - S2 registers ed = |exact - y_approx|, computed as the larger minus the smaller, plus the flag ne = (ed != 0).
  - The accumulators update on the cycle after S2 is valid. Retire latency from handshake to counter update is 3 cycles.
- Arithmetic:
  - err_count += ne.
  - sample_count += 1.
  - sum_ed += ed, zero-extended. On overflow sum_ed clamps at 2^ACC_W-1 and stays there.
  - max_ed = max(max_ed, ed).
- DONE is entered exactly when sample_count == n_samples_latched and the pipeline is empty. It is never entered early.
- start while busy is ignored and does not affect the latched n_samples.
- in_valid while not in RUN is ignored, and the sample is not counted.
- Back-to-back handshakes sustain 1 sample per cycle. Gaps in in_valid insert bubbles but do not change results.

Decomposition:
- Package approx_err_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE}
  - defaults for W, CNT_W and ACC_W
  - the ACC_MAX saturation constant
- Sub-module approx_err_stage: the S1/S2 datapath (exact multiply, absolute difference, valid pipeline). The top module keeps the FSM, counters and accumulators.

Test Plan:
- Exact DUT model (y_approx = a*b), n_samples=1000, random a and b, in_valid held high. Required: done after about 1003 cycles, err_count=0, sum_ed=0, max_ed=0, sample_count=1000.
- Directed errors, n_samples=3:
  - (a=3, b=5, y=14) gives ed=1.
  - (a=65535, b=65535, y=0) gives ed=4294836225.
  - (a=2, b=2, y=4) gives ed=0.
  - Required: err_count=2, sum_ed=4294836226, max_ed=4294836225.
- n_samples=0 with start. Required: done within 2 cycles, all results 0, in_ready never high.
- Random in_valid gaps (50% duty), n_samples=16, y=a*b+1. Required: err_count=16, sum_ed=16, in_ready low after the 16th handshake, and extra valid samples not counted.
- Assert rst_n=0 for 1 cycle mid-RUN after 5 samples. Required: all outputs 0 and state IDLE immediately, with no clock needed. A later start with n_samples=4 yields sample_count=4.
- start pulse during RUN (n_samples=10, second start carrying n_samples=2). Required: ignored, and the window completes with sample_count=10.
